// File: rtl/npu_xpe_pkg.sv
// Shared XPE definitions: result-beat lane geometry and out-writer FSM states.
package npu_xpe_pkg;

    localparam int XPE_LANES  = 32;
    localparam int XPE_LANE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } xpe_wr_state_e;

endpackage

// File: rtl/xpe_wr_fifo.sv
// Synchronous skid FIFO; head entry and full/empty flags come straight from flops.
module xpe_wr_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_dat,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_last
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              do_push, do_pop;

    assign do_pop  = i_pop & ~empty_q;
    // A full FIFO may still take a beat when the head leaves in the same cycle.
    assign do_push = i_push & (~full_q | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d   = (cnt_d == (AW+1)'(DEPTH));
        empty_d  = (cnt_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= i_dat;
        end
    end

    assign o_head  = mem[rd_ptr_q];
    assign o_full  = full_q;
    assign o_empty = empty_q;
    assign o_last  = (cnt_q == (AW+1)'(1));

endmodule

// File: rtl/xpe_out_writer.sv
// XPE result sink: buffers beats and writes them linearly to the output-buffer SRAM.
// Optional XPE_WR_STALL_CNT_EN adds o_stall_cnt (cycles with a write waiting on ready).
module xpe_out_writer
    import npu_xpe_pkg::*;
#(
    parameter int DATA_W     = XPE_LANES * XPE_LANE_W,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_beat_num,
    input  logic [DATA_W-1:0] i_xpe_dat,
    input  logic              i_xpe_dat_vld,
    input  logic              i_wr_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_dat,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
`ifdef XPE_WR_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

    xpe_wr_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic              ovf_q, ovf_d;

    logic              fifo_full, fifo_empty, fifo_last;
    logic [DATA_W-1:0] fifo_head;
    logic              start_ok, push, pop, drop;

    // The FIFO head is the write port: a non-empty FIFO is a pending write.
    assign pop      = ~fifo_empty & i_wr_ready;
    assign push     = (state_q == ST_RUN) & i_xpe_dat_vld & (~fifo_full | pop);
    assign drop     = i_xpe_dat_vld & ~push;
    assign start_ok = (state_q == ST_IDLE) & i_start;

    xpe_wr_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_dat   (i_xpe_dat),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_last  (fifo_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_d   = acc_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    num_d   = i_beat_num;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (i_beat_num == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (push) begin
                    acc_d = acc_q + CNT_W'(1);
                    if (acc_q + CNT_W'(1) == num_q) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Finish as soon as the final write is leaving, so done follows it by one cycle.
                if (fifo_empty | (fifo_last & pop)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            acc_q   <= '0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            acc_q   <= acc_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef XPE_WR_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_ok) begin
            stall_d = '0;
        end else if (~fifo_empty & ~i_wr_ready & ~(&stall_q)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

    assign o_wr_en    = ~fifo_empty;
    assign o_wr_addr  = addr_q;
    assign o_wr_dat   = {DATA_W{~fifo_empty}} & fifo_head;
    assign o_busy     = (state_q == ST_RUN) | (state_q == ST_FLUSH);
    assign o_done     = (state_q == ST_DONE);
    assign o_overflow = ovf_q;

endmodule
